seq_alu: RTL



---
 rtl/alu_pkg.sv | 29 ++
 rtl/seq_muldiv_core.sv | 108 ++++++++++
 rtl/seq_alu.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the sequential ALU and its sub-blocks.
package alu_pkg;

    localparam logic [4:0] Add  = 5'b00000;
    localparam logic [4:0] Sub  = 5'b00001;
    localparam logic [4:0] And  = 5'b00010;
    localparam logic [4:0] Or   = 5'b00011;
    localparam logic [4:0] Shr  = 5'b00100;
    localparam logic [4:0] Shra = 5'b00101;
    localparam logic [4:0] Shl  = 5'b00110;
    localparam logic [4:0] Ror  = 5'b00111;
    localparam logic [4:0] Rol  = 5'b01000;
    localparam logic [4:0] Div  = 5'b01100;
    localparam logic [4:0] Mul  = 5'b01101;
    localparam logic [4:0] Neg  = 5'b01110;
    localparam logic [4:0] Not  = 5'b01111;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_t;

    function automatic logic is_multi_cycle(input logic [4:0] op);
        return (op == Mul) || (op == Div);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes)
// with its own step counter; result is combinational from the iteration registers.
module seq_muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result,
    output logic                 dbz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] a_q;
    logic             sa_q, sb_q, div_q, dbz_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   m_ext, booth_sum, shifted, trial;
    logic             ge;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;
    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        unique case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
    end

    // Restoring step: bring in next dividend bit, subtract divisor only if it fits.
    assign shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, m_q};
    assign ge      = shifted >= {1'b0, m_q};

    always_comb begin
        acc_d = acc_q;
        mq_d  = mq_q;
        qm1_d = qm1_q;
        if (div_q) begin
            acc_d = ge ? trial : shifted;
            mq_d  = {mq_q[WIDTH-2:0], ge};
        end else begin
            {acc_d, mq_d, qm1_d} = {booth_sum[WIDTH], booth_sum, mq_q};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q <= '0;
            mq_q  <= '0;
            qm1_q <= 1'b0;
            m_q   <= '0;
            a_q   <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            div_q <= 1'b0;
            dbz_q <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            acc_q <= '0;
            mq_q  <= is_div ? a_abs : b;
            qm1_q <= 1'b0;
            m_q   <= is_div ? b_abs : a;
            a_q   <= a;
            sa_q  <= a[WIDTH-1];
            sb_q  <= b[WIDTH-1];
            div_q <= is_div;
            dbz_q <= is_div && (b == '0);
            cnt_q <= CW'(WIDTH);
        end else if (step) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last    = (cnt_q == CW'(1));
    assign quo_fix = (sa_q ^ sb_q) ? -mq_q : mq_q;
    assign rem_fix = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign dbz     = dbz_q;

    always_comb begin
        if (dbz_q) begin
            result = {a_q, {WIDTH{1'b1}}};
        end else if (div_q) begin
            result = {rem_fix, quo_fix};
        end else begin
            result = {acc_q[WIDTH-1:0], mq_q};
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake; single-cycle ops complete in one clock,
// Mul/Div iterate in seq_muldiv_core.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [4:0]           opcode,
    input  logic [WIDTH-1:0]     Ra,
    input  logic [WIDTH-1:0]     Rb,
    output logic [2*WIDTH-1:0]   Rc,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic                 illegal_op
);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] rc_q, rc_d;
    logic               dbz_q, dbz_d;
    logic               ill_q, ill_d;

    logic               load;
    logic               core_last;
    logic               core_dbz;
    logic [2*WIDTH-1:0] core_result;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ill;

    assign shamt = Rb[SHW-1:0];

    always_comb begin
        sc_res = '0;
        sc_ill = 1'b0;
        case (opcode)
            Add:     sc_res = Ra + Rb;
            Sub:     sc_res = Ra - Rb;
            And:     sc_res = Ra & Rb;
            Or:      sc_res = Ra | Rb;
            Shr:     sc_res = Ra >> shamt;
            Shra:    sc_res = $signed(Ra) >>> shamt;
            Shl:     sc_res = Ra << shamt;
            Ror:     sc_res = (Ra >> shamt) | (Ra << (WIDTH - shamt));
            Rol:     sc_res = (Ra << shamt) | (Ra >> (WIDTH - shamt));
            Neg:     sc_res = -Ra;
            Not:     sc_res = ~Ra;
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        dbz_d   = dbz_q;
        ill_d   = ill_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    dbz_d = 1'b0;
                    ill_d = 1'b0;
                    if (is_multi_cycle(opcode)) begin
                        load    = 1'b1;
                        state_d = StRun;
                    end else begin
                        rc_d    = {{WIDTH{1'b0}}, sc_res};
                        ill_d   = sc_ill;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (core_last) state_d = StFix;
            end
            StFix: begin
                rc_d    = core_result;
                dbz_d   = core_dbz;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            rc_q    <= '0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            dbz_q   <= dbz_d;
            ill_q   <= ill_d;
        end
    end

    seq_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .step   (state_q == StRun),
        .is_div (opcode == Div),
        .a      (Ra),
        .b      (Rb),
        .last   (core_last),
        .result (core_result),
        .dbz    (core_dbz)
    );

    assign Rc          = rc_q;
    assign busy        = (state_q == StRun) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule
